// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction classes, opcodes, funct7 values, ALU ops, field bundle.
package rv32i_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CLS_W = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;

    typedef enum logic [CLS_W-1:0] {
        CLS_LOAD   = 4'd0,
        CLS_OPIMM  = 4'd1,
        CLS_AUIPC  = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_OP     = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_BRANCH = 4'd6,
        CLS_JALR   = 4'd7,
        CLS_JAL    = 4'd8
    } insn_cls_e;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    // ALU operation set used by the decoder
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    // Instruction field bundle presented to the encoder
    typedef struct packed {
        logic [CLS_W-1:0] cls;
        logic [F3_W-1:0]  funct3;
        logic             alt;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
    } insn_fields_t;

    // True when v is representable as a two's-complement value of 'bits' bits
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
        logic [XLEN-1:0] hi;
        hi = XLEN'($signed(v) >>> (bits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/insn_enc.sv
// Combinational RV32I encoder: packs fields into a word and flags illegal inputs.
module insn_enc
    import rv32i_pkg::*;
(
    input  insn_fields_t    fields,
    output logic [XLEN-1:0] word_c,
    output logic            illegal_c
);

    logic [XLEN-1:0]  imm;
    logic [F3_W-1:0]  f3;
    logic [F7_W-1:0]  f7;
    logic             i_ok;
    logic             b_ok;
    logic             j_ok;
    logic             sh_ok;
    logic             u_ok;

    // Immediate range qualifiers shared by all formats
    always_comb begin
        imm   = fields.imm;
        f3    = fields.funct3;
        f7    = fields.alt ? F7_ALT : F7_BASE;
        i_ok  = fits_signed(imm, 12);
        b_ok  = fits_signed(imm, 13) && !imm[0];
        j_ok  = fits_signed(imm, 21) && !imm[0];
        sh_ok = (imm[XLEN-1:5] == '0);
        u_ok  = (imm[11:0] == '0);
    end

    // Per-class legality and field packing
    always_comb begin
        word_c    = '0;
        illegal_c = 1'b0;
        case (fields.cls)
            CLS_LOAD: begin
                illegal_c = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || !i_ok;
                word_c    = {imm[11:0], fields.rs1, f3, fields.rd, OPC_LOAD};
            end
            CLS_OPIMM: begin
                if ((f3 == 3'b001) || (f3 == 3'b101)) begin
                    illegal_c = !sh_ok || (fields.alt && (f3 != 3'b101));
                    word_c    = {f7, imm[4:0], fields.rs1, f3, fields.rd, OPC_OPIMM};
                end else begin
                    illegal_c = fields.alt || !i_ok;
                    word_c    = {imm[11:0], fields.rs1, f3, fields.rd, OPC_OPIMM};
                end
            end
            CLS_AUIPC: begin
                illegal_c = !u_ok;
                word_c    = {imm[31:12], fields.rd, OPC_AUIPC};
            end
            CLS_STORE: begin
                illegal_c = f3[2] || (f3 == 3'b011) || !i_ok;
                word_c    = {imm[11:5], fields.rs2, fields.rs1, f3, imm[4:0], OPC_STORE};
            end
            CLS_OP: begin
                illegal_c = fields.alt && (f3 != 3'b000) && (f3 != 3'b101);
                word_c    = {f7, fields.rs2, fields.rs1, f3, fields.rd, OPC_OP};
            end
            CLS_LUI: begin
                illegal_c = !u_ok;
                word_c    = {imm[31:12], fields.rd, OPC_LUI};
            end
            CLS_BRANCH: begin
                illegal_c = (f3 == 3'b010) || (f3 == 3'b011) || !b_ok;
                word_c    = {imm[12], imm[10:5], fields.rs2, fields.rs1, f3,
                             imm[4:1], imm[11], OPC_BRANCH};
            end
            CLS_JALR: begin
                illegal_c = (f3 != 3'b000) || !i_ok;
                word_c    = {imm[11:0], fields.rs1, f3, fields.rd, OPC_JALR};
            end
            CLS_JAL: begin
                illegal_c = !j_ok;
                word_c    = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, OPC_JAL};
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/insn_enc_ldr.sv
// Streams encoded RV32I words into instruction memory, one word every two cycles.
module insn_enc_ldr
    import rv32i_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [XLEN-1:0]  i_base_addr,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [CLS_W-1:0] i_cls,
    input  logic [F3_W-1:0]  i_funct3,
    input  logic             i_alt,
    input  logic [REG_W-1:0] i_rd,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic [XLEN-1:0]  i_imm,
    input  logic             i_last,
    output logic             o_imem_wren,
    output logic [XLEN-1:0]  o_imem_addr,
    output logic [XLEN-1:0]  o_imem_wdata,
    output logic             o_err,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count
);

    typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_e;

    state_e          state_q;
    state_e          state_d;
    insn_fields_t    fields_c;
    logic [XLEN-1:0] word_c;
    logic            illegal_c;
    logic            last_q;

    assign fields_c = '{cls: i_cls, funct3: i_funct3, alt: i_alt, rd: i_rd,
                        rs1: i_rs1, rs2: i_rs2, imm: i_imm};

    insn_enc u_enc (
        .fields    (fields_c),
        .word_c    (word_c),
        .illegal_c (illegal_c)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN: begin
                if (i_vld) begin
                    if (illegal_c) state_d = i_last ? DONE : RUN;
                    else           state_d = WRITE;
                end
            end
            WRITE:   state_d = last_q ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, address/count bookkeeping and captured word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdy        <= 1'b0;
            o_imem_wren  <= 1'b0;
            o_done       <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_err        <= 1'b0;
            o_count      <= '0;
            last_q       <= 1'b0;
        end else begin
            o_rdy       <= (state_d == RUN);
            o_imem_wren <= (state_d == WRITE);
            o_done      <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        o_imem_addr <= i_base_addr & ~XLEN'(3);
                        o_count     <= '0;
                        o_err       <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_vld) begin
                        if (illegal_c) begin
                            o_err <= 1'b1;
                        end else begin
                            o_imem_wdata <= word_c;
                            last_q       <= i_last;
                        end
                    end
                end
                WRITE: begin
                    o_imem_addr <= o_imem_addr + XLEN'(4);
                    if (o_count != '1) o_count <= o_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_enc_ldr.sv
// Directed bench for insn_enc_ldr with a write scoreboard checked by a monitor.
module tb_insn_enc_ldr;

    localparam logic [3:0] C_LOAD   = 4'd0;
    localparam logic [3:0] C_OPIMM  = 4'd1;
    localparam logic [3:0] C_STORE  = 4'd3;
    localparam logic [3:0] C_OP     = 4'd4;
    localparam logic [3:0] C_LUI    = 4'd5;
    localparam logic [3:0] C_BRANCH = 4'd6;
    localparam logic [3:0] C_JAL    = 4'd8;
    localparam logic [3:0] C_BAD    = 4'd9;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic        i_vld;
    logic        o_rdy;
    logic [3:0]  i_cls;
    logic [2:0]  i_funct3;
    logic        i_alt;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic [31:0] i_imm;
    logic        i_last;
    logic        o_imem_wren;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_err;
    logic        o_done;
    logic [15:0] o_count;

    int          checks    = 0;
    int          failures  = 0;
    int          done_cnt  = 0;
    int          done_base = 0;
    logic [31:0] addr_m    = '0;
    exp_t        exp_q[$];

    insn_enc_ldr dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_vld        (i_vld),
        .o_rdy        (o_rdy),
        .i_cls        (i_cls),
        .i_funct3     (i_funct3),
        .i_alt        (i_alt),
        .i_rd         (i_rd),
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .i_imm        (i_imm),
        .i_last       (i_last),
        .o_imem_wren  (o_imem_wren),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_err        (o_err),
        .o_done       (o_done),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (o_done === 1'b1) done_cnt++;
        if (o_imem_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wren: addr 0x%08h data 0x%08h with empty scoreboard",
                         o_imem_addr, o_imem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", o_imem_addr, e.addr);
                check("wr_data", o_imem_wdata, e.data);
            end
        end
    end

    task automatic start_load(input logic [31:0] base);
        done_base   = done_cnt;
        i_start     = 1'b1;
        i_base_addr = base;
        @(negedge clk);
        i_start = 1'b0;
        addr_m  = base & ~32'd3;
        check("start_rdy",   32'(o_rdy),   32'd1);
        check("start_addr",  o_imem_addr,  addr_m);
        check("start_err",   32'(o_err),   32'd0);
        check("start_count", 32'(o_count), 32'd0);
    endtask

    task automatic send(input string nm, input logic [3:0] cls, input logic [2:0] f3,
                        input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                        input logic legal, input logic [31:0] word);
        int n;
        n = 0;
        while (o_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (o_rdy !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_rdy_timeout: got o_rdy=%0b expected 1", nm, o_rdy);
            return;
        end
        i_vld = 1'b1; i_cls = cls; i_funct3 = f3; i_alt = alt;
        i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_last = last;
        if (legal) exp_q.push_back('{addr: addr_m, data: word});
        @(negedge clk);
        i_vld = 1'b0;
        check({nm, "_wren"}, 32'(o_imem_wren), 32'(legal));
        if (legal) begin
            addr_m = addr_m + 32'd4;
        end else begin
            check({nm, "_addr_hold"}, o_imem_addr, addr_m);
            check({nm, "_err"}, 32'(o_err), 32'd1);
        end
    endtask

    task automatic finish_load(input string nm, input int cnt, input logic err);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (o_done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_done_timeout: got o_done=%0b expected 1", nm, o_done);
        end
        @(negedge clk);
        check({nm, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
        check({nm, "_idle_rdy"},    32'(o_rdy),   32'd0);
        check({nm, "_count"},       32'(o_count), 32'(cnt));
        check({nm, "_err"},         32'(o_err),   32'(err));
        check({nm, "_addr"},        o_imem_addr,  addr_m);
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_rdy"},   32'(o_rdy),       32'd0);
        check({nm, "_wren"},  32'(o_imem_wren), 32'd0);
        check({nm, "_addr"},  o_imem_addr,      32'd0);
        check({nm, "_wdata"}, o_imem_wdata,     32'd0);
        check({nm, "_err"},   32'(o_err),       32'd0);
        check({nm, "_done"},  32'(o_done),      32'd0);
        check({nm, "_count"}, 32'(o_count),     32'd0);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_vld = 1'b0;
        i_cls = '0; i_funct3 = '0; i_alt = 1'b0; i_rd = '0; i_rs1 = '0;
        i_rs2 = '0; i_imm = '0; i_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_no_start_rdy", 32'(o_rdy), 32'd0);

        // addi then sub, basic stream
        start_load(32'h0000_0100);
        send("addi", C_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h0050_0093);
        send("sub",  C_OP,    3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h4020_81B3);
        finish_load("s1", 2, 1'b0);

        // branch, jump, upper immediate
        start_load(32'h0000_0200);
        send("beq", C_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h0020_8463);
        send("jal", C_JAL,    3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, 1'b1, 32'h0100_00EF);
        send("lui", C_LUI,    3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 1'b1, 32'h1234_52B7);
        finish_load("s2", 3, 1'b0);

        // illegal inputs interleaved with one legal word
        start_load(32'h0000_0300);
        send("br_odd",   C_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7,    1'b0, 1'b0, 32'd0);
        send("ld_f3",    C_LOAD,   3'b011, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0,    1'b0, 1'b0, 32'd0);
        send("addi_big", C_OPIMM,  3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'd0);
        send("addi_m1",  C_OPIMM,  3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1,
             32'hFFF0_0113);
        finish_load("s3", 1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("err_sticky_idle", 32'(o_err), 32'd1);

        // illegal last word ends the load without writing
        start_load(32'h0000_0400);
        send("bad_last", C_BAD, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 1'b0, 32'd0);
        finish_load("s4", 0, 1'b1);

        // address wrap; low base bits are ignored
        start_load(32'hFFFF_FFFE);
        send("sw",   C_STORE, 3'b010, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8, 1'b0, 1'b1, 32'h0051_2423);
        send("srai", C_OPIMM, 3'b101, 1'b1, 5'd4, 5'd4, 5'd0, 32'd3, 1'b1, 1'b1, 32'h4032_5213);
        finish_load("s5", 2, 1'b0);

        // reset asserted while the strobe is high
        start_load(32'h0000_0500);
        send("addi_rst", C_OPIMM, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h0050_0093);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_write_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_idle_rdy", 32'(o_rdy), 32'd0);
        check("post_rst_no_wren",  32'(o_imem_wren), 32'd0);

        // FSM resumes normally from IDLE
        start_load(32'h0000_0600);
        send("lui2", C_LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 1'b1, 32'h1234_52B7);
        finish_load("s6", 1, 1'b0);

        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
